ws2812_chain_tx: RTL and testbench

//  Parametrised WS2812-family serial encoder that drives one LED strand of NUM_LED pixels per frame.

---
 rtl/ws2812_chain_tx.sv | 152 +++++++++++++++
 tb/tb_ws2812_chain_tx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_chain_tx.sv
// WS2812-family strand encoder: valid/ready pixel stream in, MSB-first return-to-zero symbols
// out, one-pixel holding buffer for gapless pixels, and a low latch period closing each frame.
module ws2812_chain_tx #(
  parameter int PIX_BITS = 24,
  parameter int NUM_LED  = 8,
  parameter int T_BIT    = 60,
  parameter int T0H      = 20,
  parameter int T1H      = 40,
  parameter int T_RST    = 2500
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [PIX_BITS-1:0] pix_data,
  input  logic                pix_valid,
  output logic                pix_ready,
  output logic                busy,
  output logic                frame_done,
  output logic                underrun,
  output logic                dout
);

  localparam int SW = $clog2(T_BIT + 1);
  localparam int BW = $clog2(PIX_BITS + 1);
  localparam int CW = $clog2(NUM_LED + 1);
  localparam int LW = $clog2(T_RST + 1);

  localparam logic [SW-1:0] SYM_LAST = SW'(T_BIT - 1);
  localparam logic [SW-1:0] HI0      = SW'(T0H);
  localparam logic [SW-1:0] HI1      = SW'(T1H);
  localparam logic [BW-1:0] BIT_LAST = BW'(PIX_BITS - 1);
  localparam logic [CW-1:0] NUM_C    = CW'(NUM_LED);
  localparam logic [LW-1:0] LAT_LAST = LW'(T_RST - 1);

  typedef enum logic [1:0] {IDLE, FILL, SEND, LATCH} state_t;

  state_t              state_reg, state_next;
  logic [PIX_BITS-1:0] buf_reg, shift_reg;
  logic                buf_full_reg;
  logic [SW-1:0]       sym_cnt_reg;
  logic [BW-1:0]       bit_idx_reg;
  logic [CW-1:0]       acc_cnt_reg, sent_cnt_reg;
  logic [LW-1:0]       lat_cnt_reg;
  logic                pix_ready_reg, busy_reg, frame_done_reg, underrun_reg, dout_reg;

  logic                xfer, sym_end, last_bit, load;
  logic [CW-1:0]       acc_next;
  logic [SW-1:0]       sym_inc, hi_len;
  logic [LW-1:0]       lat_inc;

  always_comb begin
    xfer     = pix_valid & pix_ready_reg;
    sym_end  = (state_reg == SEND) && (sym_cnt_reg == SYM_LAST);
    last_bit = (bit_idx_reg == BIT_LAST);
    // the shifter takes the buffered pixel either to open the frame or to follow the last bit
    load     = buf_full_reg && ((state_reg == FILL) || (sym_end && last_bit));
    acc_next = (state_reg == IDLE && start) ? '0 : acc_cnt_reg + CW'(xfer);
    sym_inc  = sym_cnt_reg + 1'b1;
    lat_inc  = lat_cnt_reg + 1'b1;
    hi_len   = shift_reg[PIX_BITS-1] ? HI1 : HI0;

    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = FILL;
      FILL:    if (buf_full_reg) state_next = SEND;
      SEND:    if (sym_end && last_bit && !buf_full_reg) state_next = LATCH;
      LATCH:   if (lat_cnt_reg == LAT_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      buf_reg        <= '0;
      shift_reg      <= '0;
      buf_full_reg   <= 1'b0;
      sym_cnt_reg    <= '0;
      bit_idx_reg    <= '0;
      acc_cnt_reg    <= '0;
      sent_cnt_reg   <= '0;
      lat_cnt_reg    <= '0;
      pix_ready_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      underrun_reg   <= 1'b0;
      dout_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      busy_reg       <= (state_next != IDLE);
      acc_cnt_reg    <= acc_next;
      frame_done_reg <= 1'b0;
      // ready stays low through the cycle after a drain so the source sees a clean handshake
      pix_ready_reg  <= ((state_next == FILL) || (state_next == SEND)) &&
                        !buf_full_reg && !xfer && (acc_next < NUM_C);
      underrun_reg   <= sym_end && last_bit && !buf_full_reg && (sent_cnt_reg != NUM_C);

      if (xfer) begin
        buf_reg      <= pix_data;
        buf_full_reg <= 1'b1;
      end else if (load) begin
        buf_full_reg <= 1'b0;
      end

      if (load) begin
        shift_reg    <= buf_reg;
        bit_idx_reg  <= '0;
        sym_cnt_reg  <= '0;
        dout_reg     <= 1'b1;
        sent_cnt_reg <= sent_cnt_reg + 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            dout_reg <= 1'b0;
            if (start) sent_cnt_reg <= '0;
          end
          FILL: dout_reg <= 1'b0;
          SEND: begin
            if (!sym_end) begin
              sym_cnt_reg <= sym_inc;
              dout_reg    <= (sym_inc < hi_len);
            end else if (!last_bit) begin
              shift_reg   <= shift_reg << 1;
              bit_idx_reg <= bit_idx_reg + 1'b1;
              sym_cnt_reg <= '0;
              dout_reg    <= 1'b1;
            end else begin
              lat_cnt_reg    <= '0;
              dout_reg       <= 1'b0;
              frame_done_reg <= (T_RST == 1);
            end
          end
          LATCH: begin
            dout_reg <= 1'b0;
            if (lat_cnt_reg != LAT_LAST) begin
              lat_cnt_reg    <= lat_inc;
              frame_done_reg <= (lat_inc == LAT_LAST);
            end
          end
          default: dout_reg <= 1'b0;
        endcase
      end
    end
  end

  assign pix_ready  = pix_ready_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign underrun   = underrun_reg;
  assign dout       = dout_reg;

endmodule

// File: tb/tb_ws2812_chain_tx.sv
// Scoreboard bench for ws2812_chain_tx: a monitor decodes dout into (high, low) symbol runs and
// underrun markers and checks them against expectations queued by the stimulus.
`timescale 1ns/1ps
module tb_ws2812_chain_tx;
  localparam int T_RST = 2500;
  localparam int K_SYM = 0;
  localparam int K_UR  = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [23:0] pix_data_a;
  logic [31:0] pix_data_b;
  logic        pix_valid_a, pix_valid_b;
  logic        pix_ready_a, busy_a, frame_done_a, underrun_a, dout_a;
  logic        pix_ready_b, busy_b, frame_done_b, underrun_b, dout_b;

  always #5 clk = ~clk;

  ws2812_chain_tx #(.PIX_BITS(24), .NUM_LED(2), .T_BIT(60), .T0H(20), .T1H(40), .T_RST(T_RST)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .pix_data(pix_data_a), .pix_valid(pix_valid_a),
    .pix_ready(pix_ready_a), .busy(busy_a), .frame_done(frame_done_a), .underrun(underrun_a),
    .dout(dout_a));

  ws2812_chain_tx #(.PIX_BITS(32), .NUM_LED(1), .T_BIT(60), .T0H(20), .T1H(40), .T_RST(T_RST)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .pix_data(pix_data_b), .pix_valid(pix_valid_b),
    .pix_ready(pix_ready_b), .busy(busy_b), .frame_done(frame_done_b), .underrun(underrun_b),
    .dout(dout_b));

  typedef struct packed {
    int inst;
    int kind;
    int a;
    int b;
  } evt_t;

  evt_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [1:0] dout_w, fd_w, ur_w, busy_w;
  assign dout_w = {dout_b, dout_a};
  assign fd_w   = {frame_done_b, frame_done_a};
  assign ur_w   = {underrun_b, underrun_a};
  assign busy_w = {busy_b, busy_a};

  bit    in_sym[2];
  bit    prev_d[2];
  int    hcnt[2];
  int    lcnt[2];
  longint first_rise[2];

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic check_evt(input int inst, input int kind, input int a, input int b);
    evt_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL evt_unexpected: got inst%0d kind%0d (%0d,%0d) expected nothing", inst, kind, a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.inst != inst || e.kind != kind || e.a != a || e.b != b) begin
        n_bad++;
        $display("FAIL evt: got inst%0d kind%0d (%0d,%0d) expected inst%0d kind%0d (%0d,%0d) @%0t",
                 inst, kind, a, b, e.inst, e.kind, e.a, e.b, $time);
      end else begin
        $display("evt ok inst%0d kind%0d (%0d,%0d)", inst, kind, a, b);
      end
    end
  endtask

  // decode: a symbol is a high run plus the low run up to the next rise or the frame_done cycle
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        in_sym[i] = 1'b0; prev_d[i] = 1'b0; hcnt[i] = 0; lcnt[i] = 0;
      end else begin
        if (dout_w[i]) begin
          if (!prev_d[i]) begin
            if (in_sym[i]) check_evt(i, K_SYM, hcnt[i], lcnt[i]);
            else first_rise[i] = $time;
            in_sym[i] = 1'b1; hcnt[i] = 1; lcnt[i] = 0;
          end else begin
            hcnt[i]++;
          end
        end else if (in_sym[i]) begin
          lcnt[i]++;
        end
        if (ur_w[i]) check_evt(i, K_UR, lcnt[i], 0);
        if (fd_w[i]) begin
          check_evt(i, K_SYM, in_sym[i] ? hcnt[i] : 0, lcnt[i]);
          in_sym[i] = 1'b0;
        end
        prev_d[i] = dout_w[i];
      end
    end
  end

  task automatic push_pix(input int inst, input logic [31:0] pix, input int nbits,
                          input bit last_frame, input bit ur_after);
    int h, lo;
    for (int b = nbits - 1; b >= 0; b--) begin
      h  = pix[b] ? 40 : 20;
      lo = 60 - h;
      if (b == 0 && ur_after) exp_q.push_back('{inst, K_UR, lo + 1, 0});
      if (b == 0 && (last_frame || ur_after)) lo += T_RST;
      exp_q.push_back('{inst, K_SYM, h, lo});
    end
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic feed_a(input logic [23:0] d);
    bit got;
    got = 1'b0;
    pix_data_a  = d;
    pix_valid_a = 1'b1;
    for (int n = 0; n < 20000 && !got; n++) begin
      if (pix_ready_a) begin
        @(posedge clk);
        got = 1'b1;
      end
      @(negedge clk);
    end
    pix_valid_a = 1'b0;
    chk("feed_accept", int'(got), 1);
  endtask

  task automatic wait_idle(input int inst, input int want_len);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 12000 && !done; n++) begin
      @(negedge clk);
      if (!busy_w[inst]) done = 1'b1;
    end
    chk("idle_reached", int'(done), 1);
    chk("frame_len", int'(($time - first_rise[inst]) / 10), want_len);
  endtask

  task automatic run_t1();
    push_pix(0, 32'h800001, 24, 1'b0, 1'b0);
    push_pix(0, 32'h00FF00, 24, 1'b1, 1'b0);
    pulse_start_a();
    chk("t1_busy", int'(busy_a), 1);
    feed_a(24'h800001);
    feed_a(24'h00FF00);
    wait_idle(0, 2 * 24 * 60 + T_RST);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    pix_data_a = '0; pix_data_b = '0; pix_valid_a = 1'b0; pix_valid_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", int'(dout_a), 0);
    chk("rst_ready", int'(pix_ready_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_fdone", int'(frame_done_a), 0);
    chk("rst_underrun", int'(underrun_a), 0);
    chk("rst_dout_b", int'(dout_b), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // T1: basic two-pixel frame
    run_t1();

    // T2: pixel offered ahead of start, buffer refill timing, gapless pixel boundary
    push_pix(0, 32'hA5C3F0, 24, 1'b0, 1'b0);
    push_pix(0, 32'h0F0F01, 24, 1'b1, 1'b0);
    pix_data_a = 24'hA5C3F0; pix_valid_a = 1'b1;
    @(negedge clk);
    pulse_start_a();
    feed_a(24'hA5C3F0);
    pix_data_a = 24'h0F0F01; pix_valid_a = 1'b1;
    chk("t2_fill_dout", int'(dout_a), 0);
    @(negedge clk);
    chk("t2_first_rise", int'(dout_a), 1);
    chk("t2_ready_drain", int'(pix_ready_a), 0);
    @(negedge clk);
    chk("t2_ready_rerise", int'(pix_ready_a), 1);
    feed_a(24'h0F0F01);
    wait_idle(0, 2 * 24 * 60 + T_RST);

    // T3: second pixel withheld -> underrun, aborted frame still latches
    push_pix(0, 32'h800001, 24, 1'b0, 1'b1);
    pulse_start_a();
    feed_a(24'h800001);
    wait_idle(0, 24 * 60 + T_RST);
    @(negedge clk);
    chk("t3_busy_after", int'(busy_a), 0);
    chk("t3_ready_after", int'(pix_ready_a), 0);

    // T4: stray starts ignored; start right after IDLE begins a new frame
    push_pix(0, 32'h5A5A5A, 24, 1'b0, 1'b0);
    push_pix(0, 32'hC0FFEE, 24, 1'b1, 1'b0);
    pulse_start_a();
    feed_a(24'h5A5A5A);
    feed_a(24'hC0FFEE);
    repeat (500) @(negedge clk);
    pulse_start_a();
    chk("t4_busy_send", int'(busy_a), 1);
    seen = 1'b0;
    for (int n = 0; n < 8000 && !seen; n++) begin
      @(negedge clk);
      if (frame_done_a) seen = 1'b1;
    end
    chk("t4_frame_done_seen", int'(seen), 1);
    pulse_start_a();
    chk("t4_start_in_fdone_ignored", int'(busy_a), 0);
    push_pix(0, 32'h000001, 24, 1'b0, 1'b0);
    push_pix(0, 32'hFFFFFE, 24, 1'b1, 1'b0);
    pulse_start_a();
    chk("t4_restart_busy", int'(busy_a), 1);
    feed_a(24'h000001);
    feed_a(24'hFFFFFE);
    wait_idle(0, 2 * 24 * 60 + T_RST);

    // T5: reset at counter 10 of a '1' symbol, then a clean frame
    pulse_start_a();
    feed_a(24'h800001);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      if (dout_a) seen = 1'b1;
      else @(negedge clk);
    end
    chk("t5_rise_seen", int'(seen), 1);
    repeat (10) @(negedge clk);
    chk("t5_high_at_10", int'(dout_a), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_dout", int'(dout_a), 0);
    chk("t5_rst_busy", int'(busy_a), 0);
    chk("t5_rst_ready", int'(pix_ready_a), 0);
    chk("t5_rst_fdone", int'(frame_done_a), 0);
    chk("t5_rst_underrun", int'(underrun_a), 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_t1();

    // T6: 32-bit single-pixel strand, all ones
    push_pix(1, 32'hFFFFFFFF, 32, 1'b1, 1'b0);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    pix_data_b = 32'hFFFFFFFF; pix_valid_b = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      if (pix_ready_b) begin
        @(posedge clk);
        seen = 1'b1;
      end
      @(negedge clk);
    end
    pix_valid_b = 1'b0;
    chk("t6_accept", int'(seen), 1);
    wait_idle(1, 32 * 60 + T_RST);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
